gb_output_unloader: RTL and testbench



---
 rtl/gb_output_unloader_pkg.sv | 25 ++
 rtl/gb_unload_fifo.sv | 82 ++++++++
 rtl/gb_output_unloader.sv | 153 +++++++++++++++
 tb/tb_gb_output_unloader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_output_unloader_pkg.sv
// Shared definitions for the global-buffer output unloader.
// Contents: FSM state encoding, line-count width, log2 helper for the line length.
package gb_output_unloader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } unload_state_e;

  // Wide enough for a full 13b x 13b element product.
  localparam int unsigned LineCntWidth = 26;

  // Exponent of a power-of-two line length (elements per buffer line).
  function automatic int unsigned log2_len(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gb_unload_fifo.sv
// Output staging FIFO for the unloader.
// Synchronous Depth x Width FIFO with occupancy count, same-cycle push/pop and a
// synchronous clear. Storage is reset so the head reads zero after reset.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         drop all entries (pointers/count to zero)
//   push_i/data_i   write one entry; caller guarantees space
//   pop_i           remove head entry (ignored when empty)
//   head_o          current head entry
//   count_o         occupancy
//   empty_o         no entries held
module gb_unload_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_i, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gb_output_unloader.sv
// Global-buffer readback engine. On start it streams ceil(N*F/length) buffer lines,
// beginning at INIT_OUTPUT_ADDR, to the host over valid/ready, one line per beat.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start                      one-cycle pulse, begins an unload (ignored while busy)
//   INIT_OUTPUT_ADDR           first line address
//   N_SAMPLE, OUTPUT_FEATURE_LENGTH  points and features per point
//   gb_ren/gb_raddr/gb_rdata   global buffer read port (data one cycle after ren)
//   m_valid/m_ready/m_data/m_last    output stream
//   busy                       unload in progress
//   done                       one-cycle pulse after the last beat is accepted
module gb_output_unloader
  import gb_output_unloader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned length                = 16,
  parameter int unsigned global_buf_addr_width = 16,
  parameter int unsigned FIFO_DEPTH            = 2
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [global_buf_addr_width-1:0] INIT_OUTPUT_ADDR,
  input  logic [12:0]                      N_SAMPLE,
  input  logic [12:0]                      OUTPUT_FEATURE_LENGTH,
  output logic                             gb_ren,
  output logic [global_buf_addr_width-1:0] gb_raddr,
  input  logic [DATA_WIDTH*length-1:0]     gb_rdata,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*length-1:0]     m_data,
  output logic                             m_last,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned LineW   = DATA_WIDTH * length;
  localparam int unsigned LenLog2 = log2_len(length);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW      = global_buf_addr_width;

  unload_state_e           state_q, state_d;
  logic [LineCntWidth-1:0] remaining_q, remaining_d;
  logic [LineCntWidth-1:0] total_q, total_d;
  logic [LineCntWidth-1:0] beat_idx_q, beat_idx_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    inflight_q, inflight_d;

  logic [LineCntWidth-1:0] product;
  logic [LineCntWidth:0]   rounded;
  logic [LineCntWidth-1:0] line_count;
  logic [CntW-1:0]         fifo_count;
  logic                    fifo_empty;
  logic                    fifo_clear;
  logic                    pop;
  logic [CntW:0]           credit_used;

  // ceil(N*F / length) via add-then-shift; extra top bit keeps the carry.
  assign product    = {13'd0, N_SAMPLE} * {13'd0, OUTPUT_FEATURE_LENGTH};
  assign rounded    = {1'b0, product} + (LineCntWidth + 1)'(length - 1);
  assign line_count = LineCntWidth'(rounded >> LenLog2);

  assign m_valid  = !fifo_empty;
  assign pop      = m_valid && m_ready;
  assign m_last   = m_valid && (beat_idx_q == total_q - LineCntWidth'(1));
  assign gb_raddr = addr_q;

  // Slots already spoken for once this cycle's pop is accounted for; a read is
  // only issued when its return is guaranteed a FIFO entry.
  assign credit_used = (CntW + 1)'(fifo_count) + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    beat_idx_d  = beat_idx_q;
    addr_d      = addr_q;
    gb_ren      = 1'b0;
    fifo_clear  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    if (pop) beat_idx_d = beat_idx_q + LineCntWidth'(1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d     = line_count;
          remaining_d = line_count;
          addr_d      = INIT_OUTPUT_ADDR;
          beat_idx_d  = '0;
          fifo_clear  = 1'b1;
          state_d     = (line_count != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        busy   = 1'b1;
        gb_ren = (remaining_q != '0) && (credit_used < (CntW + 1)'(FIFO_DEPTH));
        if (gb_ren) begin
          remaining_d = remaining_q - LineCntWidth'(1);
          addr_d      = addr_q + AW'(1);
          if (remaining_q == LineCntWidth'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && m_last) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    inflight_d = gb_ren;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      total_q     <= '0;
      beat_idx_q  <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      beat_idx_q  <= beat_idx_d;
      addr_q      <= addr_d;
      inflight_q  <= inflight_d;
    end
  end

  // Read data returns the cycle after gb_ren and is captured at the end of it.
  gb_unload_fifo #(
    .Width (LineW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .clear_i (fifo_clear),
    .push_i  (inflight_q),
    .data_i  (gb_rdata),
    .pop_i   (pop),
    .head_o  (m_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_gb_output_unloader.sv
// Bench for gb_output_unloader: stimulus pushes expected reads/beats into queues,
// an independent monitor pops and compares on each read issue and each handshake.
module tb_gb_output_unloader;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         start = 1'b0;
  logic [15:0]  init_addr = '0;
  logic [12:0]  n_sample = '0;
  logic [12:0]  ofl = '0;
  logic         gb_ren;
  logic [15:0]  gb_raddr;
  logic [127:0] gb_rdata = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;

  gb_output_unloader #(
    .DATA_WIDTH            (8),
    .length                (16),
    .global_buf_addr_width (16),
    .FIFO_DEPTH            (DEPTH)
  ) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .start                 (start),
    .INIT_OUTPUT_ADDR      (init_addr),
    .N_SAMPLE              (n_sample),
    .OUTPUT_FEATURE_LENGTH (ofl),
    .gb_ren                (gb_ren),
    .gb_raddr              (gb_raddr),
    .gb_rdata              (gb_rdata),
    .m_valid               (m_valid),
    .m_ready               (m_ready),
    .m_data                (m_data),
    .m_last                (m_last),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer contents: each line is a distinct function of its address.
  function automatic logic [127:0] line_of(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1111, a[7:0], a[15:8],
            a ^ 16'hC3C3, a - 16'h0101, a[3:0], a[15:4]};
  endfunction

  always @(posedge clk) if (gb_ren) gb_rdata <= line_of(gb_raddr);

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] addr_exp_q[$];
  beat_t       exp_b;
  int          tests = 0;
  int          fails = 0;
  int          beats = 0;
  int          done_cnt = 0;
  int          outstanding = 0;
  logic        prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      addr_exp_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, prev_data);
      end
      if (gb_ren) begin
        if (addr_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: got addr %h expected no read (t=%0t)", gb_raddr, $time);
        end else begin
          check("read_addr", gb_raddr, addr_exp_q.pop_front());
        end
      end
      if (m_valid && m_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected no beat (t=%0t)", m_data, $time);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat_data", m_data, exp_b.data);
          check("beat_last", m_last, exp_b.last);
        end
      end
      outstanding = outstanding + int'(gb_ren) - int'(m_valid && m_ready);
      if (gb_ren) check("credit_bound", outstanding <= DEPTH, 1);
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Queue the expected reads and beats, then pulse start; c0 = cycle number of edge E0.
  task automatic do_start(input logic [15:0] a, input logic [12:0] ns, input logic [12:0] f,
                          input int k, output int c0);
    for (int i = 0; i < k; i++) begin
      logic [15:0] ad;
      beat_t       b;
      ad     = a + 16'(i);
      b.data = line_of(ad);
      b.last = (i == k - 1);
      exp_q.push_back(b);
      addr_exp_q.push_back(ad);
    end
    @(posedge clk);
    #1;
    init_addr = a;
    n_sample  = ns;
    ofl       = f;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = int'(cyc);
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input bit chk_time,
                           input bit rnd, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (chk_time) check({name, "_done_cycle"}, cyc, exp_cyc);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 0);
      end else if (rnd) begin
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(0, 9) < 3);
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", name, bound);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_gb_ren"}, gb_ren, 0);
    check({name, "_gb_raddr"}, gb_raddr, 0);
    check({name, "_m_valid"}, m_valid, 0);
    check({name, "_m_data"}, m_data, 0);
    check({name, "_m_last"}, m_last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int dc;
    int b0;

    #2;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Full throughput: 1024*64/16 = 4096 lines from 0x8000, done at E0+4098.
    m_ready = 1'b1;
    do_start(16'h8000, 13'd1024, 13'd64, 4096, c0);
    check("full_busy", busy, 1);
    wait_done("full", c0 + 4098, 1'b1, 1'b0, 5000);
    check("full_all_beats", exp_q.size(), 0);

    // Backpressure: same stream, ~30% ready duty.
    m_ready = 1'b0;
    do_start(16'h8000, 13'd1024, 13'd64, 4096, c0);
    wait_done("backpressure", 0, 1'b0, 1'b1, 40000);
    check("backpressure_all_beats", exp_q.size(), 0);
    m_ready = 1'b1;

    // 3*8 = 24 elements -> 2 lines, done at E0+4.
    do_start(16'h0010, 13'd3, 13'd8, 2, c0);
    wait_done("nonmultiple", c0 + 4, 1'b1, 1'b0, 20);

    // Zero length: no reads, done in the cycle right after E0.
    do_start(16'h4000, 13'd0, 13'd37, 0, c0);
    wait_done("zero", c0, 1'b1, 1'b0, 20);
    check("zero_busy", busy, 0);

    // Wrap 0xFFFE..0x0001 with an ignored second start; done at E0+6.
    dc = done_cnt;
    do_start(16'hFFFE, 13'd4, 13'd16, 4, c0);
    @(posedge clk);
    #1;
    init_addr = 16'h1234;
    n_sample  = 13'd100;
    ofl       = 13'd16;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("wrap", c0 + 6, 1'b1, 1'b0, 20);
    repeat (5) @(posedge clk);
    #1;
    check("wrap_single_done", done_cnt - dc, 1);
    check("wrap_idle", busy, 0);

    // Reset mid-run: stall after a few beats of a 16-line unload, then reset.
    b0 = beats;
    do_start(16'h0200, 13'd16, 13'd16, 16, c0);
    for (int i = 0; i < 50 && (beats - b0) < 5; i++) begin
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    check("midrun_valid", m_valid, 1);
    dc   = done_cnt;
    rstn = 1'b0;
    #1;
    check_idle_outputs("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrun_no_done", done_cnt - dc, 0);
    check("midrun_after_valid", m_valid, 0);
    m_ready = 1'b1;
    do_start(16'h0200, 13'd16, 13'd16, 16, c0);
    wait_done("restart", c0 + 18, 1'b1, 1'b0, 40);
    check("restart_all_beats", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
